fifo_serial_tx: RTL and testbench
=================================

# fifo_serial_tx

Downstream drain stage for the 10-bit synchronous FIFO. Pops one word at a time through the FIFO read port (`rd_en`/`Dout`/`empty`) and shifts it out on a single asynchronous serial line: start bit, data LSB first, optional parity, one stop bit. Sits between the FIFO and the board-level TX pin. Owns the FIFO read-enable exclusively.

## Interface
Parameters:
- `DATA_W`, 10: word width; must match FIFO `Din`/`Dout` width.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range 2..65535.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  permits starting a new frame; never aborts a frame in progress.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_dout`  in  DATA_W  FIFO `Dout`; valid the cycle after `fifo_rd_en` is high.
- `fifo_rd_en`  out  1  FIFO pop strobe; high for exactly one cycle per word.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- Reset values: `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_done`=0, state IDLE, shift register 0, bit and baud counters 0.
- States and transitions:
  - IDLE: if `enable && !fifo_empty` go to POP, else stay.
  - POP: `fifo_rd_en`=1, decoded from state. Always go to LOAD.
  - LOAD: capture `fifo_dout` into the shift register. Go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: `tx` = shift register bit 0. After each CLKS_PER_BIT cycles, shift right. After DATA_W bits go to PARITY when enabled, else STOP.
  - PARITY: `tx` = XOR of the captured word (even parity) for CLKS_PER_BIT cycles, then STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. `frame_done` is high in the final cycle. On exit, go to POP if `enable && !fifo_empty`, else IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; width $clog2(CLKS_PER_BIT). Bit counter width $clog2(DATA_W+1).
- `fifo_empty` is sampled only in IDLE and in the last STOP cycle. A pop is therefore never issued to an empty FIFO, since this block is the sole reader.
- `tx` is registered and glitch-free.

## Timing
- Start latency: when `enable && !fifo_empty` is first sampled in IDLE at cycle 0, POP is cycle 1, LOAD is cycle 2, and `tx` falls in cycle 3.
- Frame length is (DATA_W+2)·CLKS_PER_BIT cycles, or (DATA_W+3)·CLKS_PER_BIT with parity.
- Back-to-back frames: exactly 2 cycles of `tx`=1 (POP, LOAD) between one stop bit and the next start bit.
- `enable` dropping mid-frame: the frame completes normally, then the block enters IDLE.
- `fifo_empty` asserting mid-frame: no effect until the last STOP cycle.
- `rst` mid-frame: outputs take their reset values at the next edge and the in-flight word is discarded. A word popped in POP but not yet loaded is also lost.
- `rst` in the same cycle as a STOP-exit pop decision: reset wins and `fifo_rd_en` stays 0.

## Configuration
- `FIFO_SERIAL_TX_PARITY_EN` defined: the PARITY state is compiled in and every frame carries an even-parity bit after the data.
- Undefined: the PARITY state and the XOR logic are absent, and DATA goes directly to STOP.

## Structure
- Shared package `fifo_serial_tx_pkg` holds:
  - the state enum type (IDLE, POP, LOAD, START, DATA, PARITY, STOP);
  - the default DATA_W and CLKS_PER_BIT localparams.
- One sub-module, `serial_bit_timer`:
  - the baud counter, with a synchronous clear input;
  - a `bit_tick` output that pulses on the last cycle of each bit period.
- The FSM, shift register and bit counter stay in the top module.

## Test plan
All scenarios use DATA_W=10 and CLKS_PER_BIT=4.
- Reset: hold `rst` for 3 cycles mid-frame. Next edge: `tx`=1, `busy`=0, `fifo_rd_en`=0, and no `frame_done` pulse.
- Single word 10'h2A5, no parity: `fifo_rd_en` is high for exactly 1 cycle. `tx` sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,0,1,1. Frame is 48 cycles, with `frame_done` in cycle 47 of the frame.
- Same word with `FIFO_SERIAL_TX_PARITY_EN`: parity bit 1 appears before the stop bit, and the frame is 52 cycles.
- Three words 10'h001, 10'h3FF, 10'h155 preloaded: exactly 2 idle-high cycles between frames, 3 pops total, and `busy` high throughout.
- Drop `enable` during the DATA bits of word 1 with 2 words queued: word 1 completes, no further pop occurs, and the block returns to IDLE. Re-assert `enable`: `tx` falls 3 cycles later.
- FIFO empty: `enable` high for 100 cycles with `fifo_empty`=1 gives no `fifo_rd_en` and `tx` held at 1.

Source files
------------

// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and default parameters for the FIFO-to-serial drain stage.
package fifo_serial_tx_pkg;

   localparam int unsigned DEF_DATA_W       = 10;
   localparam int unsigned DEF_CLKS_PER_BIT = 16;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

endpackage

// File: rtl/fifo_serial_tx_if.sv
// FIFO read port plus serial line bundle; master is the drain stage, slave is the FIFO/board side.
interface fifo_serial_tx_if
   import fifo_serial_tx_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) ();

   logic              enable;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_rd_en;
   logic              tx;
   logic              busy;
   logic              frame_done;

   modport master (
      input  enable, fifo_empty, fifo_dout,
      output fifo_rd_en, tx, busy, frame_done
   );

   modport slave (
      output enable, fifo_empty, fifo_dout,
      input  fifo_rd_en, tx, busy, frame_done
   );

endinterface

// File: rtl/serial_bit_timer.sv
// Baud counter for one serial bit period; bit_tick marks the last cycle, pre_tick the one before.
module serial_bit_timer
   import fifo_serial_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_tick,
   output logic pre_tick
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign bit_tick = !clear && (cnt == LAST);
   assign pre_tick = !clear && (cnt == PRE);

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from the FIFO and shifts them out as start/data(LSB first)/stop frames.
// Define FIFO_SERIAL_TX_PARITY_EN to add an even-parity bit after the data bits.
module fifo_serial_tx
   import fifo_serial_tx_pkg::*;
#(
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic             clk,
   input  logic             rst,
   fifo_serial_tx_if.master bus
);

   localparam int unsigned BIT_W = $clog2(DATA_W + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   state_t            state;
   logic [DATA_W-1:0] shift_reg;
   logic [DATA_W-1:0] shift_nx;
   logic [BIT_W-1:0]  bit_cnt;
   logic              timer_clear;
   logic              bit_tick;
   logic              pre_tick;
   logic              start_ok;
`ifdef FIFO_SERIAL_TX_PARITY_EN
   logic              parity_bit;
`endif

   assign shift_nx    = shift_reg >> 1;
   assign start_ok    = bus.enable && !bus.fifo_empty;
   // Baud counter only runs while a bit is on the line.
   assign timer_clear = (state == IDLE) || (state == POP) || (state == LOAD);

   serial_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (timer_clear),
      .bit_tick (bit_tick),
      .pre_tick (pre_tick)
   );

   // Outputs are set on the transition into the state that owns them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         shift_reg      <= '0;
         bit_cnt        <= '0;
         bus.tx         <= 1'b1;
         bus.fifo_rd_en <= 1'b0;
         bus.busy       <= 1'b0;
         bus.frame_done <= 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
         parity_bit     <= 1'b0;
`endif
      end else begin
         bus.fifo_rd_en <= 1'b0;
         bus.frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  state          <= POP;
                  bus.fifo_rd_en <= 1'b1;
                  bus.busy       <= 1'b1;
               end
            end
            POP: begin
               state <= LOAD;
            end
            LOAD: begin
               shift_reg  <= bus.fifo_dout;
               bit_cnt    <= '0;
               bus.tx     <= 1'b0;
               state      <= START;
`ifdef FIFO_SERIAL_TX_PARITY_EN
               parity_bit <= ^bus.fifo_dout;
`endif
            end
            START: begin
               if (bit_tick) begin
                  bus.tx <= shift_reg[0];
                  state  <= DATA;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  bit_cnt   <= bit_cnt + BIT_W'(1);
                  shift_reg <= shift_nx;
                  if (bit_cnt == LAST_BIT) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
                     bus.tx <= parity_bit;
                     state  <= PARITY;
`else
                     bus.tx <= 1'b1;
                     state  <= STOP;
`endif
                  end else begin
                     bus.tx <= shift_nx[0];
                  end
               end
            end
`ifdef FIFO_SERIAL_TX_PARITY_EN
            PARITY: begin
               if (bit_tick) begin
                  bus.tx <= 1'b1;
                  state  <= STOP;
               end
            end
`endif
            STOP: begin
               if (pre_tick) begin
                  bus.frame_done <= 1'b1;
               end
               if (bit_tick) begin
                  if (start_ok) begin
                     state          <= POP;
                     bus.fifo_rd_en <= 1'b1;
                  end else begin
                     state    <= IDLE;
                     bus.busy <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               bus.tx   <= 1'b1;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: FIFO model, serial-line decoder and expected-word scoreboard.
module tb_fifo_serial_tx;

   localparam int unsigned DW  = 10;
   localparam int unsigned CPB = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
   localparam int NB = 13;
`else
   localparam int NB = 12;
`endif
   localparam int FRAME = NB * CPB;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fifo_serial_tx_if #(.DATA_W(DW)) bus ();

   fifo_serial_tx #(
      .DATA_W       (DW),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] mem [0:63];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int pops = 0;
   int empty_pops = 0;
   int rd_run = 0;
   int rd_run_max = 0;
   int cyc = 0;
   int fd_total = 0;
   int frames = 0;
   logic [DW-1:0] exp_q [$];
   int start_t [$];

   assign bus.fifo_empty = (wr_ptr == rd_ptr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input logic [DW-1:0] w, input bit scored);
      mem[wr_ptr % 64] = w;
      wr_ptr++;
      if (scored) exp_q.push_back(w);
   endtask

   // FIFO read port: registered Dout valid the cycle after rd_en
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.frame_done) fd_total <= fd_total + 1;
      if (bus.fifo_rd_en) begin
         rd_run <= rd_run + 1;
         if (rd_run + 1 > rd_run_max) rd_run_max <= rd_run + 1;
         if (wr_ptr == rd_ptr) begin
            empty_pops <= empty_pops + 1;
         end else begin
            bus.fifo_dout <= mem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
            pops <= pops + 1;
         end
      end else begin
         rd_run <= 0;
      end
   end

   // Line decoder: rebuilds each frame from tx and checks it against the scoreboard
   initial begin : mon
      logic [NB-1:0] bits;
      logic [DW-1:0] w;
      logic [DW-1:0] e;
      int unstable;
      int fd_cnt;
      int fd_at;
      bit aborted;
      forever begin
         @(negedge clk);
         if (!rst && bus.tx === 1'b0) begin
            start_t.push_back(cyc);
            bits = '0;
            unstable = 0;
            fd_cnt = 0;
            fd_at = -1;
            aborted = 1'b0;
            for (int c = 0; c < FRAME; c++) begin
               if (c > 0) @(negedge clk);
               if (rst) aborted = 1'b1;
               if (c % CPB == 0) bits[c / CPB] = bus.tx;
               else if (bus.tx !== bits[c / CPB]) unstable++;
               if (bus.frame_done === 1'b1) begin
                  fd_cnt++;
                  fd_at = c;
               end
            end
            @(negedge clk);
            if (rst) aborted = 1'b1;
            if (!aborted) begin
               check("frame_tail_high", 32'(bus.tx), 32'd1);
               check("start_bit", 32'(bits[0]), 32'd0);
               check("bit_stable", unstable, 0);
               check("stop_bit", 32'(bits[NB-1]), 32'd1);
               check("frame_done_cnt", fd_cnt, 1);
               check("frame_done_at", fd_at, FRAME - 1);
               w = bits[DW:1];
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("frame_word", 32'(w), 32'(e));
`ifdef FIFO_SERIAL_TX_PARITY_EN
                  check("parity_bit", 32'(bits[NB-2]), 32'(^e));
`endif
               end
               frames++;
            end
         end
      end
   end

   initial begin : main
      int lows;
      int rdh;
      int base;
      int f0;
      int fd0;
      int busy_lo;

      bus.enable = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(bus.tx), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      check("rst_frame_done", 32'(bus.frame_done), 32'd0);
      rst = 1'b0;

      // Enabled but empty FIFO: nothing may happen
      bus.enable = 1'b1;
      lows = 0;
      rdh = 0;
      busy_lo = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.tx !== 1'b1) lows++;
         if (bus.fifo_rd_en !== 1'b0) rdh++;
         if (bus.busy !== 1'b0) busy_lo++;
      end
      check("empty_tx_low", lows, 0);
      check("empty_rd_en", rdh, 0);
      check("empty_busy", busy_lo, 0);

      // Single word
      base = pops;
      f0 = frames;
      push(10'h2A5, 1'b1);
      for (int i = 0; i < 200 && frames < f0 + 1; i++) @(negedge clk);
      check("single_frames", frames, f0 + 1);
      check("single_pops", pops - base, 1);
      check("single_rd_pulse", rd_run_max, 1);
      check("single_idle", 32'(bus.busy), 32'd0);

      // Three back-to-back words
      bus.enable = 1'b0;
      @(negedge clk);
      push(10'h001, 1'b1);
      push(10'h3FF, 1'b1);
      push(10'h155, 1'b1);
      start_t.delete();
      base = pops;
      f0 = frames;
      fd0 = fd_total;
      busy_lo = 0;
      bus.enable = 1'b1;
      for (int i = 0; i < 600 && frames < f0 + 3; i++) begin
         @(negedge clk);
         if (start_t.size() > 0 && fd_total < fd0 + 3 && bus.busy !== 1'b1) busy_lo++;
      end
      check("b2b_frames", frames, f0 + 3);
      check("b2b_pops", pops - base, 3);
      check("b2b_busy_low", busy_lo, 0);
      check("b2b_starts", start_t.size(), 3);
      if (start_t.size() == 3) begin
         check("b2b_gap01", start_t[1] - start_t[0], FRAME + 2);
         check("b2b_gap12", start_t[2] - start_t[1], FRAME + 2);
      end

      // Drop enable mid-frame with words still queued
      bus.enable = 1'b0;
      @(negedge clk);
      push(10'h0C3, 1'b1);
      push(10'h21E, 1'b1);
      push(10'h37A, 1'b1);
      base = pops;
      f0 = frames;
      bus.enable = 1'b1;
      for (int i = 0; i < 20 && bus.tx !== 1'b0; i++) @(negedge clk);
      check("drop_start", 32'(bus.tx), 32'd0);
      repeat (12) @(negedge clk);
      bus.enable = 1'b0;
      for (int i = 0; i < 200 && frames < f0 + 1; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      check("drop_frames", frames, f0 + 1);
      check("drop_pops", pops - base, 1);
      check("drop_idle", 32'(bus.busy), 32'd0);
      bus.enable = 1'b1;
      @(negedge clk);
      check("reen_c1", 32'(bus.tx), 32'd1);
      @(negedge clk);
      check("reen_c2", 32'(bus.tx), 32'd1);
      @(negedge clk);
      check("reen_fall", 32'(bus.tx), 32'd0);
      for (int i = 0; i < 400 && frames < f0 + 3; i++) @(negedge clk);
      check("reen_frames", frames, f0 + 3);
      check("reen_pops", pops - base, 3);

      // Reset mid-frame: word is discarded, outputs return to idle at once
      push(10'h0F0, 1'b0);
      for (int i = 0; i < 20 && bus.tx !== 1'b0; i++) @(negedge clk);
      check("rst_mid_start", 32'(bus.tx), 32'd0);
      repeat (10) @(negedge clk);
      f0 = frames;
      rst = 1'b1;
      bus.enable = 1'b0;
      @(negedge clk);
      check("rst_mid_tx", 32'(bus.tx), 32'd1);
      check("rst_mid_busy", 32'(bus.busy), 32'd0);
      check("rst_mid_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      check("rst_mid_fd", 32'(bus.frame_done), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      fd0 = fd_total;
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.tx !== 1'b1) lows++;
      end
      check("rst_after_fd", fd_total - fd0, 0);
      check("rst_after_tx", lows, 0);
      check("rst_after_frames", frames, f0);

      check("scoreboard_empty", exp_q.size(), 0);
      check("no_empty_pops", empty_pops, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
